// File: rtl/cntr_ctrl_pkg.sv
// Shared definitions for the counter command sequencer: command opcodes and FSM states.
package cntr_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_DIR  = 2'b01,
        OP_SEEK = 2'b10,
        OP_HOLD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_SEEK,
        S_DONE
    } state_e;

endpackage

// File: rtl/cntr_cmd_ctrl.sv
// Command sequencer driving a loadable up/down counter: LOAD, DIR, SEEK (shortest
// modular path with timeout) and HOLD (freeze by repeated reload of the stepped value).
module cntr_cmd_ctrl
    import cntr_ctrl_pkg::*;
#(
    parameter int unsigned W       = 4,
    parameter int unsigned TMO_CYC = 2**W + 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    input  logic [W-1:0] cnt,
    output logic         load_en,
    output logic [W-1:0] load_data,
    output logic         up_dnb,
    output logic         done,
    output logic         err
);

    localparam int unsigned CMAX = (TMO_CYC > 2**W - 1) ? TMO_CYC : 2**W - 1;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

    // Up when the forward distance is at most half the ring; the tie goes up.
    function automatic logic seek_up(input logic [W-1:0] target, input logic [W-1:0] cur);
        logic [W-1:0] d;
        d = target - cur;
        return (d <= HALF);
    endfunction

    state_e        state_q, state_d;
    logic          load_en_q, load_en_d;
    logic [W-1:0]  load_data_q, load_data_d;
    logic          up_dnb_q, up_dnb_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [W-1:0]  target_q, target_d;
    logic [CW-1:0] ctr_q, ctr_d;

    assign cmd_ready = (state_q == S_IDLE) & ~reset;
    assign load_en   = load_en_q;
    assign load_data = load_data_q;
    assign up_dnb    = up_dnb_q;
    assign done      = done_q;
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        load_en_d   = 1'b0;
        load_data_d = load_data_q;
        up_dnb_d    = up_dnb_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        target_d    = target_q;
        ctr_d       = ctr_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (op_e'(cmd_op))
                        OP_LOAD: begin
                            load_data_d = cmd_data;
                            load_en_d   = 1'b1;
                            state_d     = S_LOAD;
                        end
                        OP_DIR: begin
                            up_dnb_d = cmd_data[0];
                            done_d   = 1'b1;
                            state_d  = S_DONE;
                        end
                        OP_SEEK: begin
                            up_dnb_d = seek_up(cmd_data, cnt);
                            target_d = cmd_data;
                            ctr_d    = '0;
                            state_d  = S_SEEK;
                        end
                        OP_HOLD: begin
                            if (cmd_data == '0) begin
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                load_data_d = up_dnb_q ? cnt + 1'b1 : cnt - 1'b1;
                                load_en_d   = 1'b1;
                                ctr_d       = CW'(cmd_data) - CW'(1);
                                state_d     = S_HOLD;
                            end
                        end
                    endcase
                end
            end
            S_LOAD: begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_HOLD: begin
                if (ctr_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    load_en_d = 1'b1;
                    ctr_d     = ctr_q - 1'b1;
                end
            end
            S_SEEK: begin
                // A match wins over expiry in the same cycle.
                if (cnt == target_q) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (ctr_q == CW'(TMO_CYC - 1)) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            load_en_q   <= 1'b0;
            load_data_q <= '0;
            up_dnb_q    <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            target_q    <= '0;
            ctr_q       <= '0;
        end else begin
            state_q     <= state_d;
            load_en_q   <= load_en_d;
            load_data_q <= load_data_d;
            up_dnb_q    <= up_dnb_d;
            done_q      <= done_d;
            err_q       <= err_d;
            target_q    <= target_d;
            ctr_q       <= ctr_d;
        end
    end

endmodule

// File: tb/tb_cntr_cmd_ctrl.sv
// Bench for cntr_cmd_ctrl paired with a 4-bit up/down counter; expectations come from
// per-command timing rules computed arithmetically at each accept.
module tb_cntr_cmd_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] cnt;
    logic       load_en;
    logic [3:0] load_data;
    logic       up_dnb;
    logic       done;
    logic       err;
    logic       stuck = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic       exp_dir;
    logic [3:0] exp_ld;

    always #5 clk = ~clk;

    cntr_cmd_ctrl #(.W(4), .TMO_CYC(18)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cnt       (cnt),
        .load_en   (load_en),
        .load_data (load_data),
        .up_dnb    (up_dnb),
        .done      (done),
        .err       (err)
    );

    // Counter under control; 'stuck' freezes it so a SEEK can time out.
    always @(posedge clk) begin
        if (reset)        cnt <= 4'd0;
        else if (!stuck)  cnt <= load_en ? load_data : (up_dnb ? cnt + 4'd1 : cnt - 4'd1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cnt(input logic [3:0] v);
        for (int i = 0; i < 40; i++) begin
            if (cnt == v) break;
            @(negedge clk);
        end
        chk("wait_cnt", 32'(cnt), 32'(v));
    endtask

    // Issue one command in the current (idle) cycle and check every cycle up to the next idle one.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] data);
        logic [3:0] c0, c1, hv, ck, d, nld;
        logic dir0, ndir, xerr;
        int unsigned lat;
        chk("ready_pre", 32'(cmd_ready), 32'd1);
        c0   = cnt;
        dir0 = exp_dir;
        ndir = dir0;
        nld  = exp_ld;
        xerr = 1'b0;
        hv   = dir0 ? c0 + 4'd1 : c0 - 4'd1;
        c1   = stuck ? c0 : hv;
        lat  = 1;
        case (op)
            2'b00: begin nld = data; lat = 2; end
            2'b01: begin ndir = data[0]; lat = 1; end
            2'b10: begin
                d    = data - c0;
                ndir = (d <= 4'd8);
                lat  = 19;
                xerr = 1'b1;
                for (int k = 1; k <= 18; k++) begin
                    ck = stuck ? c0 : (ndir ? c1 + 4'(k - 1) : c1 - 4'(k - 1));
                    if (ck == data) begin
                        lat  = k + 1;
                        xerr = 1'b0;
                        break;
                    end
                end
            end
            default: begin
                if (data == 4'd0) lat = 1;
                else begin
                    nld = hv;
                    lat = 32'(data) + 1;
                end
            end
        endcase
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        for (int unsigned k = 1; k <= lat; k++) begin
            @(negedge clk);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom);
            cmd_data  = 4'($urandom);
            chk("done", 32'(done), 32'(k == lat));
            if (k == lat) chk("err", 32'(err), 32'(xerr));
            chk("ready_busy", 32'(cmd_ready), 32'd0);
            chk("up_dnb", 32'(up_dnb), 32'(ndir));
            chk("load_data", 32'(load_data), 32'(nld));
            chk("load_en", 32'(load_en),
                32'((op == 2'b00 && k == 1) || (op == 2'b11 && data != 4'd0 && k <= 32'(data))));
            if (op == 2'b00 && k == 2) chk("load_cnt", 32'(cnt), 32'(data));
            if (op == 2'b11 && data != 4'd0) chk("hold_cnt", 32'(cnt), 32'(hv));
            if (op == 2'b10 && !xerr && k == lat - 1) chk("seek_cnt", 32'(cnt), 32'(data));
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        if (op == 2'b11 && data != 4'd0)
            chk("hold_resume", 32'(cnt), 32'(dir0 ? hv + 4'd1 : hv - 4'd1));
        exp_dir = ndir;
        exp_ld  = nld;
    endtask

    initial begin
        logic [3:0] t;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 4'd0;
        exp_dir   = 1'b1;
        exp_ld    = 4'd0;

        repeat (3) @(negedge clk);
        chk("rst_load_en", 32'(load_en), 32'd0);
        chk("rst_load_data", 32'(load_data), 32'd0);
        chk("rst_up_dnb", 32'(up_dnb), 32'd1);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        run_cmd(2'b00, 4'hA);

        run_cmd(2'b01, 4'h0);
        wait_cnt(4'h5);
        run_cmd(2'b10, 4'h3);
        wait_cnt(4'h2);
        run_cmd(2'b10, 4'hE);
        wait_cnt(4'h2);
        run_cmd(2'b10, 4'hA);

        t = exp_dir ? cnt + 4'd1 : cnt - 4'd1;
        run_cmd(2'b10, t);
        run_cmd(2'b10, cnt);

        run_cmd(2'b01, 4'h1);
        wait_cnt(4'h7);
        run_cmd(2'b11, 4'h5);
        run_cmd(2'b11, 4'h0);

        stuck = 1'b1;
        run_cmd(2'b10, cnt + 4'd5);
        stuck = 1'b0;

        chk("mid_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_data  = 4'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_load_en", 32'(load_en), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_load_en", 32'(load_en), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_up_dnb", 32'(up_dnb), 32'd1);
        reset   = 1'b0;
        exp_dir = 1'b1;
        exp_ld  = 4'd0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_ready", 32'(cmd_ready), 32'd1);
            chk("post_rst_load_en", 32'(load_en), 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_cmd(2'($urandom), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
